// File: rtl/tone_output_arbiter.sv
// rtl/tone_output_arbiter.sv - fixed-priority owner arbiter for the shared piezo/LED tone output
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   req[2:0]   requests: [0]=alert, [1]=key echo, [2]=playback (lowest index wins)
//   req_note   4-bit note per requester, [3:0] belongs to req[0]; 4'h0 is a rest
//   req_dur    4-bit note length in ticks per requester; 0 plays as 1 tick
//   grant      one-hot owner, held through PLAY and GAP
//   done       one-cycle pulse to the owner after its note and gap complete
//   abort      one-cycle pulse to an owner that was preempted by the alert
//   piezo_out  note currently sounding (0 when silent)
//   led_out    mirror of piezo_out
//   busy       high whenever the arbiter is not idle
module tone_output_arbiter #(
    parameter int TICK_DIV  = 5000000,
    parameter int GAP_TICKS = 1,
    parameter int PREEMPT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [11:0] req_note,
    input  logic [11:0] req_dur,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [2:0]  abort,
    output logic [3:0]  piezo_out,
    output logic [3:0]  led_out,
    output logic        busy
);

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]    GAP_LOAD  = 4'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt, tick_cnt_nxt;
    logic [3:0]    remaining, remaining_nxt;
    logic [2:0]    grant_nxt, done_nxt, abort_nxt;
    logic [3:0]    note_nxt;
    logic [2:0]    win;
    logic [3:0]    win_note, win_dur;
    logic          tick, last_tick, preempt;

    // Lowest asserted request index wins; its note/dur are selected here.
    always_comb begin
        win      = 3'b000;
        win_note = req_note[3:0];
        win_dur  = req_dur[3:0];
        if (req[0]) begin
            win = 3'b001;
        end else if (req[1]) begin
            win      = 3'b010;
            win_note = req_note[7:4];
            win_dur  = req_dur[7:4];
        end else if (req[2]) begin
            win      = 3'b100;
            win_note = req_note[11:8];
            win_dur  = req_dur[11:8];
        end
    end

    assign tick      = (tick_cnt == TICK_LAST);
    assign last_tick = tick && (remaining <= 4'd1);
    // The alert takes over any non-alert owner; it wins over a same-edge completion.
    assign preempt   = (PREEMPT != 0) && req[0] && (state != IDLE) && !grant[0];

    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick ? '0 : tick_cnt + CW'(1);
        remaining_nxt = remaining;
        grant_nxt     = grant;
        done_nxt      = 3'b000;
        abort_nxt     = 3'b000;
        note_nxt      = piezo_out;

        case (state)
            IDLE: begin
                tick_cnt_nxt = '0;
                if (win != 3'b000) begin
                    grant_nxt     = win;
                    note_nxt      = win_note;
                    remaining_nxt = (win_dur == 4'd0) ? 4'd1 : win_dur;
                    state_nxt     = PLAY;
                end
            end
            PLAY, GAP: begin
                if (preempt) begin
                    abort_nxt     = grant;
                    grant_nxt     = 3'b001;
                    note_nxt      = req_note[3:0];
                    remaining_nxt = (req_dur[3:0] == 4'd0) ? 4'd1 : req_dur[3:0];
                    tick_cnt_nxt  = '0;
                    state_nxt     = PLAY;
                end else if (last_tick) begin
                    note_nxt = 4'h0;
                    if (state == PLAY && GAP_TICKS > 0) begin
                        remaining_nxt = GAP_LOAD;
                        state_nxt     = GAP;
                    end else begin
                        done_nxt  = grant;
                        grant_nxt = 3'b000;
                        state_nxt = IDLE;
                    end
                end else if (tick) begin
                    remaining_nxt = remaining - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 3'b000;
                note_nxt  = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            remaining <= 4'd0;
            grant     <= 3'b000;
            done      <= 3'b000;
            abort     <= 3'b000;
            piezo_out <= 4'h0;
            led_out   <= 4'h0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            remaining <= remaining_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            abort     <= abort_nxt;
            piezo_out <= note_nxt;
            led_out   <= note_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_tone_output_arbiter.sv
// tb/tb_tone_output_arbiter.sv - self-checking bench for tone_output_arbiter (preempt and no-preempt instances)
module tb_tone_output_arbiter;

    localparam int TD  = 4;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_a = 3'b000;
    logic [2:0]  req_b = 3'b000;
    logic [11:0] req_note = 12'h000;
    logic [11:0] req_dur = 12'h000;

    logic [2:0] grant_a, done_a, abort_a, grant_b, done_b, abort_b;
    logic [3:0] piezo_a, led_a, piezo_b, led_b;
    logic       busy_a, busy_b;
    logic [17:0] obs_a, obs_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, [0] = preempting instance, [1] = non-preempting instance
    int         m_owner[2] = '{-1, -1};
    int         m_dur[2]   = '{0, 0};
    int         m_el[2]    = '{0, 0};
    logic [3:0] e_piezo[2] = '{4'h0, 4'h0};
    logic [2:0] e_grant[2] = '{3'b000, 3'b000};
    logic [2:0] e_done[2]  = '{3'b000, 3'b000};
    logic [2:0] e_abort[2] = '{3'b000, 3'b000};

    always #5 clk = ~clk;

    tone_output_arbiter #(.TICK_DIV(TD), .GAP_TICKS(GAP), .PREEMPT(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_note(req_note), .req_dur(req_dur),
        .grant(grant_a), .done(done_a), .abort(abort_a),
        .piezo_out(piezo_a), .led_out(led_a), .busy(busy_a)
    );

    tone_output_arbiter #(.TICK_DIV(TD), .GAP_TICKS(GAP), .PREEMPT(0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_note(req_note), .req_dur(req_dur),
        .grant(grant_b), .done(done_b), .abort(abort_b),
        .piezo_out(piezo_b), .led_out(led_b), .busy(busy_b)
    );

    assign obs_a = {grant_a, done_a, abort_a, piezo_a, led_a, busy_a};
    assign obs_b = {grant_b, done_b, abort_b, piezo_b, led_b, busy_b};

    function automatic logic [17:0] exp_vec(input int k);
        return {e_grant[k], e_done[k], e_abort[k], e_piezo[k], e_piezo[k], (m_owner[k] >= 0)};
    endfunction

    task automatic start_note(input int k, input int w);
        logic [3:0] d;
        d          = req_dur[4*w +: 4];
        m_owner[k] = w;
        m_note_set(k, req_note[4*w +: 4]);
        m_dur[k]   = (d == 4'd0) ? 1 : int'(d);
        m_el[k]    = 0;
        e_grant[k] = 3'(1 << w);
    endtask

    task automatic m_note_set(input int k, input logic [3:0] n);
        e_piezo[k] = n;
    endtask

    // Timeline model: a note granted at el=0 sounds while el < dur*TD,
    // is silent through the gap, and completes when el reaches (dur+GAP)*TD.
    logic [3:0] m_note[2] = '{4'h0, 4'h0};

    task automatic model_edge(input int k, input logic rst_n, input logic [2:0] r);
        e_done[k]  = 3'b000;
        e_abort[k] = 3'b000;
        if (!rst_n) begin
            m_owner[k] = -1;
            e_grant[k] = 3'b000;
            e_piezo[k] = 4'h0;
        end else if (m_owner[k] < 0) begin
            if (r != 3'b000) begin
                start_note(k, r[0] ? 0 : (r[1] ? 1 : 2));
                m_note[k] = e_piezo[k];
            end
        end else begin
            m_el[k]++;
            if (k == 0 && r[0] && m_owner[k] != 0) begin
                e_abort[k] = 3'(1 << m_owner[k]);
                start_note(k, 0);
                m_note[k] = e_piezo[k];
            end else if (m_el[k] == (m_dur[k] + GAP) * TD) begin
                e_done[k]  = 3'(1 << m_owner[k]);
                m_owner[k] = -1;
                e_grant[k] = 3'b000;
                e_piezo[k] = 4'h0;
            end else begin
                e_piezo[k] = (m_el[k] < m_dur[k] * TD) ? m_note[k] : 4'h0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, reset, req_a);
        model_edge(1, reset, req_b);
        #1;
    endtask

    task automatic idle_reset();
        reset = 1'b0;
        req_a = 3'b000;
        req_b = 3'b000;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        req_a    = 3'b111;
        req_b    = 3'b111;
        req_note = 12'h321;
        req_dur  = 12'h111;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs_a !== 18'h0) begin miscompares++; $display("FAIL reset_hold_a: got %h expected %h", obs_a, 18'h0); end
            vectors++;
            if (obs_b !== 18'h0) begin miscompares++; $display("FAIL reset_hold_b: got %h expected %h", obs_b, 18'h0); end
        end
        reset = 1'b1;
        step();
        vectors++;
        if (grant_a !== 3'b001) begin miscompares++; $display("FAIL reset_release_grant: got %b expected %b", grant_a, 3'b001); end
        vectors++;
        if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL reset_release_model: got %h expected %h", obs_a, exp_vec(0)); end
        idle_reset();
    endtask

    task automatic test_single_note();
        int sound = 0, busy_n = 0, done_n = 0, gap_n = 0;
        req_a = 3'b100; req_b = 3'b100;
        req_note = 12'h500; req_dur = 12'h200;
        step();
        req_a = 3'b000; req_b = 3'b000;
        vectors++;
        if (grant_a !== 3'b100) begin miscompares++; $display("FAIL single_grant: got %b expected %b", grant_a, 3'b100); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL single_model cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            if (piezo_a == 4'h5 && led_a == 4'h5) sound++;
            if (busy_a && piezo_a == 4'h0) gap_n++;
            if (busy_a) busy_n++;
            if (done_a[2]) done_n++;
            step();
        end
        vectors++;
        if (sound != 8) begin miscompares++; $display("FAIL single_sound_cycles: got %0d expected 8", sound); end
        vectors++;
        if (gap_n != 4) begin miscompares++; $display("FAIL single_gap_cycles: got %0d expected 4", gap_n); end
        vectors++;
        if (busy_n != 12) begin miscompares++; $display("FAIL single_busy_cycles: got %0d expected 12", busy_n); end
        vectors++;
        if (done_n != 1) begin miscompares++; $display("FAIL single_done_count: got %0d expected 1", done_n); end
        vectors++;
        if (grant_a !== 3'b000) begin miscompares++; $display("FAIL single_grant_release: got %b expected 000", grant_a); end
        idle_reset();
    endtask

    task automatic test_priority();
        int g1 = 1, n = 0;
        req_a = 3'b110; req_b = 3'b110;
        req_note = 12'h870; req_dur = 12'h110;
        step();
        vectors++;
        if (grant_a !== 3'b010) begin miscompares++; $display("FAIL prio_first_grant: got %b expected %b", grant_a, 3'b010); end
        while (!done_a[1] && n < 20) begin
            step();
            n++;
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL prio_model cyc=%0d: got %h expected %h", n, obs_a, exp_vec(0)); end
            if (grant_a[1]) g1++;
        end
        vectors++;
        if (!done_a[1]) begin miscompares++; $display("FAIL prio_done_timeout: got done=%b expected done[1]", done_a); end
        vectors++;
        if (g1 != 8) begin miscompares++; $display("FAIL prio_owner1_cycles: got %0d expected 8", g1); end
        req_a = 3'b100; req_b = 3'b100;
        step();
        vectors++;
        if (grant_a !== 3'b100 || piezo_a !== 4'h8) begin
            miscompares++; $display("FAIL prio_second_grant: got grant=%b note=%h expected grant=100 note=8", grant_a, piezo_a);
        end
        req_a = 3'b000; req_b = 3'b000;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL prio_tail cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
        end
        idle_reset();
    endtask

    task automatic test_preempt();
        int f_n = 0, da0 = 0, da2 = 0, ab = 0, db2_at = -1, gb0_at = -1;
        req_a = 3'b100; req_b = 3'b100;
        req_note = 12'h30F; req_dur = 12'h301;
        step();
        req_a = 3'b000; req_b = 3'b000;
        for (int i = 0; i < 4; i++) step();
        req_a = 3'b001; req_b = 3'b001;
        step();
        req_a = 3'b000;
        vectors++;
        if (abort_a !== 3'b100 || grant_a !== 3'b001) begin
            miscompares++; $display("FAIL preempt_abort: got abort=%b grant=%b expected abort=100 grant=001", abort_a, grant_a);
        end
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL preempt_model_a cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            vectors++;
            if (obs_b !== exp_vec(1)) begin miscompares++; $display("FAIL preempt_model_b cyc=%0d: got %h expected %h", i, obs_b, exp_vec(1)); end
            if (piezo_a == 4'hF) f_n++;
            if (done_a[0]) da0++;
            if (done_a[2]) da2++;
            if (abort_b != 3'b000) ab++;
            if (done_b[2] && db2_at < 0) db2_at = i;
            if (grant_b[0] && gb0_at < 0) begin gb0_at = i; req_b = 3'b000; end
            step();
        end
        vectors++;
        if (f_n != 4) begin miscompares++; $display("FAIL preempt_alert_cycles: got %0d expected 4", f_n); end
        vectors++;
        if (da0 != 1 || da2 != 0) begin miscompares++; $display("FAIL preempt_done_a: got done0=%0d done2=%0d expected 1 and 0", da0, da2); end
        vectors++;
        if (ab != 0) begin miscompares++; $display("FAIL nopreempt_abort: got %0d expected 0", ab); end
        vectors++;
        if (db2_at < 0 || gb0_at != db2_at + 1) begin
            miscompares++; $display("FAIL nopreempt_wait: got done2 at %0d grant0 at %0d expected grant0 one cycle after done2", db2_at, gb0_at);
        end
        idle_reset();
    endtask

    task automatic test_edges();
        int sound = 0, done_at = -1, busy_n = 0;
        req_a = 3'b010; req_b = 3'b010;
        req_note = 12'h070; req_dur = 12'h000;
        step();
        req_a = 3'b000; req_b = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL dur0_model cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            if (piezo_a != 4'h0) sound++;
            if (done_a[1]) done_at = i;
            step();
        end
        vectors++;
        if (sound != 4 || done_at != 9) begin miscompares++; $display("FAIL dur0_timing: got sound=%0d done_at=%0d expected 4 and 9", sound, done_at); end
        sound = 0; done_at = -1;
        req_a = 3'b100; req_b = 3'b100;
        req_note = 12'h000; req_dur = 12'h200;
        step();
        req_a = 3'b000; req_b = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL rest_model cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            if (piezo_a != 4'h0 || led_a != 4'h0) sound++;
            if (busy_a) busy_n++;
            if (done_a[2]) done_at = i;
            step();
        end
        vectors++;
        if (sound != 0 || busy_n != 12 || done_at != 13) begin
            miscompares++; $display("FAIL rest_timing: got sound=%0d busy=%0d done_at=%0d expected 0, 12, 13", sound, busy_n, done_at);
        end
        idle_reset();
    endtask

    task automatic test_reset_mid();
        int sound = 0;
        req_a = 3'b010; req_b = 3'b010;
        req_note = 12'h090; req_dur = 12'h030;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        vectors++;
        if (obs_a !== 18'h0) begin miscompares++; $display("FAIL midreset_a: got %h expected %h", obs_a, 18'h0); end
        vectors++;
        if (obs_b !== 18'h0) begin miscompares++; $display("FAIL midreset_b: got %h expected %h", obs_b, 18'h0); end
        reset = 1'b1;
        step();
        vectors++;
        if (grant_a !== 3'b010 || piezo_a !== 4'h9) begin
            miscompares++; $display("FAIL midreset_regrant: got grant=%b note=%h expected grant=010 note=9", grant_a, piezo_a);
        end
        req_a = 3'b000; req_b = 3'b000;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL midreset_model cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            if (piezo_a == 4'h9) sound++;
            step();
        end
        vectors++;
        if (sound != 12) begin miscompares++; $display("FAIL midreset_full_note: got %0d expected 12", sound); end
        idle_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) req_a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) req_b = 3'($urandom_range(0, 7));
            req_note = 12'($urandom);
            req_dur  = 12'($urandom) & 12'h333;
            reset    = ($urandom_range(0, 299) != 0);
            step();
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL random_a cyc=%0d: got %h expected %h", i, obs_a, exp_vec(0)); end
            vectors++;
            if (obs_b !== exp_vec(1)) begin miscompares++; $display("FAIL random_b cyc=%0d: got %h expected %h", i, obs_b, exp_vec(1)); end
            vectors++;
            if ((done_a != 3'b000 && abort_a != 3'b000) || !$onehot0(done_a) || !$onehot0(abort_a)) begin
                miscompares++; $display("FAIL random_pulse_excl cyc=%0d: got done=%b abort=%b expected exclusive one-hot", i, done_a, abort_a);
            end
        end
        idle_reset();
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_priority();
        test_preempt();
        test_edges();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tone_output_arbiter.md
Name: tone_output_arbiter

Overview:
- Shares the single piezo/LED output pair between three requesters: miss/alert buzzer, key-press echo, and song playback.
- Grants the resource with fixed priority and times each note in prescaled ticks.
- Inserts a silent gap after each note and reports completion or preemption back to the owner.
- Sits between the game sequencing logic and the top-level piezo_out/led_out pins.

Parameters:
- TICK_DIV, 5000000, clk cycles per duration tick; legal range ≥2.
- GAP_TICKS, 1, silent ticks after each note before done; 0 = no gap.
- PREEMPT, 1, 1 = alert requester (index 0) may preempt a lower-priority owner.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req  in  3  request per requester; [0]=alert, [1]=key echo, [2]=playback
- req_note  in  12  note codes, 4 bits per requester, [3:0]=req 0; 4'h0 = rest
- req_dur  in  12  note length in ticks, 4 bits per requester; 0 treated as 1
- grant  out  3  one-hot current owner, held through PLAY and GAP
- done  out  3  one-cycle pulse to owner when its note and gap are finished
- abort  out  3  one-cycle pulse to owner when it is preempted
- piezo_out  out  4  note currently sounding
- led_out  out  4  mirror of piezo_out
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset:
  - Sampled on the clk rising edge while reset==0.
  - Forces state IDLE; grant, done, abort, piezo_out, led_out, busy all 0; tick counter 0.
  - Reset mid-PLAY/GAP issues no done or abort.
- States: IDLE, PLAY, GAP.
- IDLE:
  - Each edge, the lowest asserted req index wins.
  - On the win edge: grant bit set, the winner's note and dur latched, piezo_out/led_out = latched note, tick counter cleared, busy=1, go to PLAY.
  - Output is visible in the cycle after the edge that sampled req.
- Sampling rules:
  - req, req_note and req_dur are sampled only at grant.
  - Later changes, including dropping req, have no effect on the current note.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Tick pulse when count==TICK_DIV-1.
  - Restarts at 0 on every grant, so PLAY lasts exactly dur*TICK_DIV cycles.
  - Remaining-tick counter is 4 bits; loaded with max(dur,1); decremented on tick.
- PLAY:
  - When the last tick is reached: piezo_out/led_out go to 0.
  - If GAP_TICKS>0, go to GAP with remaining=GAP_TICKS.
  - If GAP_TICKS=0, pulse done[owner], clear grant, go to IDLE.
- GAP:
  - Outputs 0; grant still held.
  - After GAP_TICKS ticks: pulse done[owner], clear grant, go to IDLE.
- Note 4'h0 (rest) is timed exactly like a sounding note.
- Back-to-back requests:
  - A requester must deassert req in the cycle done is high, or it is re-granted.
  - The earliest re-grant edge is the one after the done edge, so there is at least one IDLE cycle between notes.
- Preemption (PREEMPT=1):
  - Triggered in PLAY or GAP when req[0]==1 and owner != 0.
  - On that edge: abort[owner] pulses, grant moves to bit 0, alert note/dur latched, tick counter cleared, state PLAY.
  - The preempted note is not resumed; its done never fires.
  - Owner 0 is never preempted.
  - With PREEMPT=0, the alert waits for IDLE like any requester.
- done and abort:
  - Never both high in the same cycle.
  - At most one bit of each is high.
- Simultaneous done and new request: the request is arbitrated on the following IDLE edge, not on the done edge.

Test Plan (TICK_DIV=4, GAP_TICKS=1, PREEMPT=1 unless noted):
- Reset: hold reset=0 for 3 cycles with req=3'b111 → all outputs 0 throughout; after release, grant=3'b001 on the next edge.
- Single note: req[2]=1, note 4'h5, dur 2 → grant=3'b100; piezo_out=led_out=5 for 8 cycles, then 0 for 4 cycles; done[2] pulses once; grant returns to 0; busy high for 12 cycles.
- Priority: req[1] and req[2] asserted on the same edge, each dur 1 → owner 1 plays first (4+4 cycles); after done[1] and req[1] dropped, owner 2 is granted after one IDLE cycle.
- Preemption: playback note 4'h3 dur 3; assert req[0] note 4'hF dur 1 in PLAY cycle 5 → abort[2] pulses; piezo_out=F from the next cycle for 4 cycles, then gap; done[0] pulses; done[2] never asserts. Repeat with PREEMPT=0 → alert waits for done[2].
- Edge values: dur=0 → one tick (4 cycles) of sound; note 4'h0 → silent for its full duration, with done timing identical to a sounding note.
- Reset mid-operation: pull reset low during PLAY cycle 3 → next cycle all outputs 0, no done or abort; after release, a held request is re-granted from scratch.
